// File: rtl/weight_monitor_if.sv
// Bus bundle for the cabin weight monitor: sample strobe, load-cell readings,
// maintenance override in; total, overload flag, alarms and counter out.
interface weight_monitor_if #(
   parameter int unsigned NUM_CELLS = 4,
   parameter int unsigned CELL_W    = 8,
   parameter int unsigned SUM_W     = CELL_W + $clog2(NUM_CELLS)
);
   logic                                sample_valid;
   logic [NUM_CELLS-1:0][CELL_W-1:0]    cell_weight;
   logic [NUM_CELLS-1:0]                cell_enable;
   logic                                override;
   logic [SUM_W-1:0]                    total_weight;
   logic                                weight_limit_exceeded;
   logic                                door_hold;
   logic                                buzzer;
   logic [7:0]                          overload_count;

   modport master (
      output sample_valid, cell_weight, cell_enable, override,
      input  total_weight, weight_limit_exceeded, door_hold, buzzer, overload_count
   );

   modport slave (
      input  sample_valid, cell_weight, cell_enable, override,
      output total_weight, weight_limit_exceeded, door_hold, buzzer, overload_count
   );
endinterface

// File: rtl/weight_monitor.sv
// Elevator cabin overload monitor: sums enabled load cells, debounces the
// overload decision with hysteresis, and drives door-hold and buzzer alarms.
module weight_monitor_cell #(
   parameter int unsigned CELL_W = 8,
   parameter int unsigned SUM_W  = 10
) (
   input  logic [CELL_W-1:0] weight,
   input  logic              enable,
   output logic [SUM_W-1:0]  masked
);
   assign masked = enable ? SUM_W'(weight) : '0;
endmodule

module weight_monitor #(
   parameter int unsigned NUM_CELLS = 4,
   parameter int unsigned CELL_W    = 8,
   parameter int unsigned LIMIT     = 600,
   parameter int unsigned HYST      = 40,
   parameter int unsigned DEBOUNCE  = 4,
   parameter int unsigned BUZZ_HALF = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   weight_monitor_if.slave bus
);
   localparam int unsigned SUM_W = CELL_W + $clog2(NUM_CELLS);
   localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
   localparam int unsigned BT_W  = $clog2(BUZZ_HALF + 1);
   localparam logic [CNT_W-1:0] DEB_L  = CNT_W'(DEBOUNCE);
   localparam logic [BT_W-1:0]  BUZ_L  = BT_W'(BUZZ_HALF - 1);
   localparam int unsigned      CLR_LVL = LIMIT - HYST;

   typedef enum logic [1:0] {NORMAL, PEND_OVER, OVERLOAD, PEND_CLEAR} state_t;

   state_t                          state, state_nxt;
   logic [CNT_W-1:0]                cnt, cnt_nxt, cnt_inc;
   logic [NUM_CELLS-1:0][SUM_W-1:0] masked;
   logic [SUM_W-1:0]                sum_c, total_q;
   logic                            eval, flag_q, over, under, enter_ovl, door_hold;
   logic [BT_W-1:0]                 buz_tmr;
   logic                            buz_ph;
   logic [7:0]                      ovl_cnt;

   for (genvar g = 0; g < NUM_CELLS; g++) begin : g_cell
      weight_monitor_cell #(.CELL_W(CELL_W), .SUM_W(SUM_W)) u_cell (
         .weight (bus.cell_weight[g]),
         .enable (bus.cell_enable[g]),
         .masked (masked[g])
      );
   end

   // SUM_W has clog2(NUM_CELLS) headroom bits, so this never wraps
   always_comb begin
      sum_c = '0;
      for (int i = 0; i < NUM_CELLS; i++) sum_c = sum_c + masked[i];
   end

   assign over    = 32'(total_q) > LIMIT;
   assign under   = 32'(total_q) < CLR_LVL;
   assign cnt_inc = cnt + 1'b1;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (eval) begin
         case (state)
            NORMAL: begin
               cnt_nxt = '0;
               if (over) begin
                  if (DEBOUNCE == 1) state_nxt = OVERLOAD;
                  else begin
                     state_nxt = PEND_OVER;
                     cnt_nxt   = CNT_W'(1);
                  end
               end
            end
            PEND_OVER: begin
               if (!over) begin
                  state_nxt = NORMAL;
                  cnt_nxt   = '0;
               end else if (cnt_inc == DEB_L) begin
                  state_nxt = OVERLOAD;
                  cnt_nxt   = '0;
               end else cnt_nxt = cnt_inc;
            end
            OVERLOAD: begin
               cnt_nxt = '0;
               if (under) begin
                  if (DEBOUNCE == 1) state_nxt = NORMAL;
                  else begin
                     state_nxt = PEND_CLEAR;
                     cnt_nxt   = CNT_W'(1);
                  end
               end
            end
            PEND_CLEAR: begin
               if (!under) begin
                  state_nxt = OVERLOAD;
                  cnt_nxt   = '0;
               end else if (cnt_inc == DEB_L) begin
                  state_nxt = NORMAL;
                  cnt_nxt   = '0;
               end else cnt_nxt = cnt_inc;
            end
            default: begin
               state_nxt = NORMAL;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // a bounce back from PEND_CLEAR is the same episode, so it is not counted
   assign enter_ovl = (state_nxt == OVERLOAD) && (state == NORMAL || state == PEND_OVER);
   assign door_hold = flag_q & ~bus.override;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= NORMAL;
         cnt     <= '0;
         eval    <= 1'b0;
         total_q <= '0;
         flag_q  <= 1'b0;
         buz_tmr <= '0;
         buz_ph  <= 1'b0;
         ovl_cnt <= '0;
      end else begin
         eval   <= bus.sample_valid;
         if (bus.sample_valid) total_q <= sum_c;
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         flag_q <= (state_nxt == OVERLOAD) || (state_nxt == PEND_CLEAR);
         if (enter_ovl && ovl_cnt != 8'hFF) ovl_cnt <= ovl_cnt + 8'd1;
         if (!door_hold) begin
            buz_tmr <= '0;
            buz_ph  <= 1'b0;
         end else if (buz_tmr == BUZ_L) begin
            buz_tmr <= '0;
            buz_ph  <= ~buz_ph;
         end else buz_tmr <= buz_tmr + 1'b1;
      end
   end

   assign bus.total_weight          = total_q;
   assign bus.weight_limit_exceeded = flag_q;
   assign bus.door_hold             = door_hold;
   assign bus.buzzer                = door_hold & ~buz_ph;
   assign bus.overload_count        = ovl_cnt;
endmodule

// File: tb/tb_weight_monitor.sv
// Directed bench for weight_monitor: debounce, hysteresis, masking, alarms,
// reset and counter saturation against hand-computed expectations.
module tb_weight_monitor;
   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_err = 0;

   weight_monitor_if #(.NUM_CELLS(4), .CELL_W(8)) bus ();

   weight_monitor #(
      .NUM_CELLS(4), .CELL_W(8), .LIMIT(600), .HYST(40), .DEBOUNCE(4), .BUZZ_HALF(8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic strobe(input logic [7:0] a, b, c, d, input logic [3:0] en);
      bus.cell_weight  = {d, c, b, a};
      bus.cell_enable  = en;
      bus.sample_valid = 1'b1;
      tick();
      bus.sample_valid = 1'b0;
   endtask

   task automatic burst(input int n, input logic [7:0] a, b, c, d, input logic [3:0] en);
      repeat (n) strobe(a, b, c, d, en);
   endtask

   initial begin
      rst_n            = 1'b0;
      bus.sample_valid = 1'b0;
      bus.cell_weight  = '0;
      bus.cell_enable  = '0;
      bus.override     = 1'b0;
      tick(2);
      rst_n = 1'b1;
      chk("rst_total", 32'(bus.total_weight), 0);
      chk("rst_flag", 32'(bus.weight_limit_exceeded), 0);
      chk("rst_door", 32'(bus.door_hold), 0);
      chk("rst_buzz", 32'(bus.buzzer), 0);
      chk("rst_count", 32'(bus.overload_count), 0);

      // 4 x 640: total after first strobe, flag two cycles after the 4th
      strobe(160, 160, 160, 160, 4'hF);
      chk("t640_total", 32'(bus.total_weight), 640);
      burst(3, 160, 160, 160, 160, 4'hF);
      chk("t640_flag_early", 32'(bus.weight_limit_exceeded), 0);
      tick();
      chk("t640_flag", 32'(bus.weight_limit_exceeded), 1);
      chk("t640_count", 32'(bus.overload_count), 1);
      chk("t640_door", 32'(bus.door_hold), 1);
      chk("buzz_first", 32'(bus.buzzer), 1);
      tick(7);
      chk("buzz_hi_end", 32'(bus.buzzer), 1);
      tick();
      chk("buzz_lo", 32'(bus.buzzer), 0);
      tick(7);
      chk("buzz_lo_end", 32'(bus.buzzer), 0);
      tick();
      chk("buzz_hi2", 32'(bus.buzzer), 1);

      // override silences alarms, leaves flag
      bus.override = 1'b1;
      #1;
      chk("ovr_door", 32'(bus.door_hold), 0);
      chk("ovr_buzz", 32'(bus.buzzer), 0);
      chk("ovr_flag", 32'(bus.weight_limit_exceeded), 1);
      tick(3);
      chk("ovr_buzz_hold", 32'(bus.buzzer), 0);
      bus.override = 1'b0;
      #1;
      chk("rel_buzz", 32'(bus.buzzer), 1);
      tick(7);
      chk("rel_buzz_hi", 32'(bus.buzzer), 1);
      tick();
      chk("rel_buzz_lo", 32'(bus.buzzer), 0);

      // hysteresis band: 570 holds, 550 clears after debounce
      burst(4, 150, 140, 140, 140, 4'hF);
      tick(2);
      chk("b570_total", 32'(bus.total_weight), 570);
      chk("b570_flag", 32'(bus.weight_limit_exceeded), 1);
      burst(4, 140, 140, 140, 130, 4'hF);
      chk("c550_flag_early", 32'(bus.weight_limit_exceeded), 1);
      tick();
      chk("c550_flag", 32'(bus.weight_limit_exceeded), 0);
      chk("c550_count", 32'(bus.overload_count), 1);

      // re-enter, then 3x550 + 570 must not drop the flag nor count again
      burst(4, 160, 160, 160, 160, 4'hF);
      tick(2);
      chk("re_flag", 32'(bus.weight_limit_exceeded), 1);
      chk("re_count", 32'(bus.overload_count), 2);
      burst(3, 140, 140, 140, 130, 4'hF);
      strobe(150, 140, 140, 140, 4'hF);
      for (int i = 0; i < 3; i++) begin
         chk("bounce_flag", 32'(bus.weight_limit_exceeded), 1);
         tick();
      end
      chk("bounce_count", 32'(bus.overload_count), 2);

      // clear, then 3x640 + 500 never sets; one more 640 alone stays clear
      burst(4, 125, 125, 125, 125, 4'hF);
      tick(2);
      chk("clr_flag", 32'(bus.weight_limit_exceeded), 0);
      burst(3, 160, 160, 160, 160, 4'hF);
      strobe(125, 125, 125, 125, 4'hF);
      tick(2);
      chk("short_flag", 32'(bus.weight_limit_exceeded), 0);
      strobe(160, 160, 160, 160, 4'hF);
      tick(3);
      chk("single_flag", 32'(bus.weight_limit_exceeded), 0);
      strobe(125, 125, 125, 125, 4'hF);
      tick(2);

      // masking
      strobe(200, 200, 200, 200, 4'h0);
      chk("mask0_total", 32'(bus.total_weight), 0);
      burst(4, 200, 200, 200, 200, 4'h7);
      tick(2);
      chk("mask7_total", 32'(bus.total_weight), 600);
      chk("mask7_flag", 32'(bus.weight_limit_exceeded), 0);
      strobe(200, 200, 200, 200, 4'hF);
      chk("maskF_total", 32'(bus.total_weight), 800);
      burst(3, 200, 200, 200, 200, 4'hF);
      tick();
      chk("maskF_flag", 32'(bus.weight_limit_exceeded), 1);
      chk("maskF_count", 32'(bus.overload_count), 3);

      // reset wins over a same-cycle sample
      rst_n            = 1'b0;
      bus.sample_valid = 1'b1;
      tick();
      rst_n            = 1'b1;
      bus.sample_valid = 1'b0;
      chk("mid_rst_total", 32'(bus.total_weight), 0);
      chk("mid_rst_flag", 32'(bus.weight_limit_exceeded), 0);
      chk("mid_rst_door", 32'(bus.door_hold), 0);
      chk("mid_rst_buzz", 32'(bus.buzzer), 0);
      chk("mid_rst_count", 32'(bus.overload_count), 0);
      tick(2);
      chk("mid_rst_hold", 32'(bus.total_weight), 0);
      chk("mid_rst_flag2", 32'(bus.weight_limit_exceeded), 0);

      // saturation
      for (int e = 0; e < 256; e++) begin
         burst(4, 160, 160, 160, 160, 4'hF);
         burst(4, 125, 125, 125, 125, 4'hF);
         tick();
         if (e == 254) chk("sat_255", 32'(bus.overload_count), 255);
      end
      chk("sat_hold", 32'(bus.overload_count), 255);
      chk("sat_flag", 32'(bus.weight_limit_exceeded), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/weight_monitor.md
WEIGHT_MONITOR -- requirements
Module: weight_monitor

Interface
REQ-001 Parameter NUM_CELLS, default 4, number of load-cell channels summed into the cabin weight.
REQ-002 Parameter CELL_W, default 8, width of each load-cell reading (unsigned, kg).
REQ-003 Parameter LIMIT, default 600, overload threshold; overload when total > LIMIT.
REQ-004 Parameter HYST, default 40, clear threshold offset; clear when total < LIMIT-HYST.
REQ-005 Parameter DEBOUNCE, default 4, consecutive qualifying samples needed to enter or leave overload (>=1).
REQ-006 Parameter BUZZ_HALF, default 8, buzzer half-period in clk cycles.
REQ-007 Derived SUM_W = CELL_W + clog2(NUM_CELLS); sum is never truncated.
REQ-008 clk  input  1  single system clock; all state changes on rising edge.
REQ-009 rst_n  input  1  synchronous, active-low reset.
REQ-010 sample_valid  input  1  one-cycle strobe; cell_weight valid this cycle.
REQ-011 cell_weight  input  NUM_CELLS*CELL_W  packed readings, cell 0 in LSBs.
REQ-012 cell_enable  input  NUM_CELLS  per-cell mask; 0 excludes a faulty cell from the sum.
REQ-013 override  input  1  maintenance key; suppresses door_hold and buzzer only.
REQ-014 total_weight  output  SUM_W  registered sum of enabled cells from last accepted sample.
REQ-015 weight_limit_exceeded  output  1  debounced overload flag.
REQ-016 door_hold  output  1  keep doors open / inhibit travel.
REQ-017 buzzer  output  1  square-wave alarm drive.
REQ-018 overload_count  output  8  number of entries into OVERLOAD, saturating.

Function
REQ-019 On a clk edge with sample_valid=1, total_weight SHALL load the sum of cells whose cell_enable bit is 1; otherwise it holds (1-cycle latency).
REQ-020 cell_enable SHALL be sampled together with cell_weight; all-zero mask yields total 0.
REQ-021 An internal strobe eval SHALL equal sample_valid delayed one cycle; FSM and debounce counter advance only when eval=1 and hold otherwise.
REQ-022 FSM states: NORMAL, PEND_OVER, OVERLOAD, PEND_CLEAR; comparisons use the current total_weight.
REQ-023 NORMAL: total>LIMIT -> PEND_OVER with cnt=1 (directly OVERLOAD if DEBOUNCE=1); else stay, cnt=0.
REQ-024 PEND_OVER: total>LIMIT -> cnt+1, OVERLOAD when cnt+1=DEBOUNCE; total<=LIMIT -> NORMAL, cnt=0.
REQ-025 OVERLOAD: total<LIMIT-HYST -> PEND_CLEAR with cnt=1 (directly NORMAL if DEBOUNCE=1); else stay, cnt=0.
REQ-026 PEND_CLEAR: total<LIMIT-HYST -> cnt+1, NORMAL when cnt+1=DEBOUNCE; else OVERLOAD, cnt=0.
REQ-027 Totals in [LIMIT-HYST, LIMIT] SHALL neither set nor clear overload (hysteresis band).
REQ-028 weight_limit_exceeded SHALL be 1 exactly in OVERLOAD and PEND_CLEAR, registered from state.
REQ-029 door_hold SHALL equal weight_limit_exceeded AND NOT override (combinational on override).
REQ-030 buzzer SHALL toggle every BUZZ_HALF cycles while door_hold=1, starting at 1 on the first door_hold cycle; buzzer=0 and its timer cleared whenever door_hold=0.
REQ-031 overload_count SHALL increment on each transition into OVERLOAD from NORMAL/PEND_OVER, saturating at 255; PEND_CLEAR->OVERLOAD SHALL not count.
REQ-032 override SHALL not affect FSM, total_weight or overload_count.
REQ-033 sample_valid asserted on consecutive cycles SHALL be accepted every cycle with no stall.

Reset
REQ-034 rst_n=0 at a clk edge SHALL force: state NORMAL, cnt 0, eval 0, total_weight 0, weight_limit_exceeded 0, buzzer 0, buzzer timer 0, overload_count 0; door_hold therefore 0.
REQ-035 Reset mid-operation (any state) SHALL take effect on that edge and override sample_valid in the same cycle.

Verification
REQ-036 Cells 160,160,160,160, mask 1111, sample_valid on 4 consecutive cycles -> total_weight=640 one cycle after first strobe; weight_limit_exceeded=1 two cycles after the 4th strobe; overload_count=1.
REQ-037 Three samples at 640 then one at 500 -> weight_limit_exceeded stays 0, state returns NORMAL.
REQ-038 In overload, four samples at 570 -> flag stays 1; then four samples at 550 -> flag 0 two cycles after 4th; 3x550 then 1x570 -> flag never drops.
REQ-039 Cells 200,200,200,200 with mask 0111 -> total_weight=600, flag stays 0; mask 1111 -> 800 and overload after debounce.
REQ-040 In overload, override=1 -> door_hold=0, buzzer=0, weight_limit_exceeded=1; override=0 -> buzzer=1 first cycle, toggles every 8 cycles.
REQ-041 rst_n=0 for one cycle while in OVERLOAD with count=3 -> all outputs 0 next cycle; 256 overload episodes -> overload_count holds 255.
